mem_port_arbiter: RTL and testbench

Shares one unified memory port between the core's instruction-fetch and data (load/store) request channels. Each cycle it grants at most one `memory_io_req` to memory and tracks the source of every outstanding request in an in-order tag FIFO. Each `memory_io_rsp` is routed back to the requester that issued it. It sits between `core` (`inst_mem_req`/`data_mem_req`) and the single-ported `memory` instance, and it returns per-channel ready signals that the core uses as stall inputs.

---
 rtl/mem_port_arbiter_pkg.sv | 33 +++
 rtl/mem_port_arbiter_tag_fifo.sv | 77 +++++++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: request/response
// structs, the source tag enum and zeroed output constants.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memory_io_req;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
    } memory_io_rsp;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_t;

    localparam memory_io_req ARB_RESET     = '0;
    localparam memory_io_rsp ARB_RSP_RESET = '0;

    // Pass a response through to a channel only when it is selected.
    function automatic memory_io_rsp route_rsp(input logic sel, input memory_io_rsp rsp);
        return sel ? rsp : ARB_RSP_RESET;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order FIFO of source tags, one entry per granted request that is
// still waiting for its memory response.
module arb_tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  arb_src_t         push_src,
    input  logic             pop,
    output arb_src_t         head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    arb_src_t         mem_q [DEPTH];
    arb_src_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; over/underflow is ignored.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_src;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SRC_INST;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data channels:
// combinational grant with data priority and fetch anti-starvation,
// and in-order routing of responses back to the issuing channel.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int STARVE_LIMIT    = 4,
    localparam int OCC_W           = $clog2(MAX_OUTSTANDING + 1),
    localparam int STARVE_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  memory_io_req     inst_req,
    output logic             inst_ready,
    output memory_io_rsp     inst_rsp,
    input  memory_io_req     data_req,
    output logic             data_ready,
    output memory_io_rsp     data_rsp,
    output memory_io_req     mem_req,
    input  memory_io_rsp     mem_rsp,
    output logic [OCC_W-1:0] outstanding,
    output logic             rsp_error
);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                rsp_error_q, rsp_error_d;
    logic                can_issue, starved;
    logic                grant_inst, grant_data;
    logic                push, pop;
    arb_src_t            push_src, head_src;
    logic                fifo_empty, fifo_full;
    logic [OCC_W-1:0]    occ;

    arb_tag_fifo #(
        .DEPTH    (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_src (push_src),
        .pop      (pop),
        .head     (head_src),
        .count    (occ),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Pick a winner: data by default, fetch alone or once data has starved it.
    always_comb begin
        can_issue  = !fifo_full && !reset;
        starved    = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
        grant_inst = can_issue && inst_req.valid && (!data_req.valid || starved);
        grant_data = can_issue && data_req.valid && !grant_inst;
        push       = grant_inst || grant_data;
        push_src   = grant_inst ? SRC_INST : SRC_DATA;
        inst_ready = grant_inst;
        data_ready = grant_data;
        mem_req    = ARB_RESET;
        if (grant_inst) begin
            mem_req = inst_req;
        end else if (grant_data) begin
            mem_req = data_req;
        end
    end

    // Count consecutive data wins over a waiting fetch, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req.valid || grant_inst) begin
            starve_cnt_d = '0;
        end else if (grant_data && !starved) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    // Route each response by the oldest tag; a response with no tag is an error.
    always_comb begin
        pop         = mem_rsp.valid && !fifo_empty && !reset;
        rsp_error_d = rsp_error_q || (mem_rsp.valid && fifo_empty);
        inst_rsp    = route_rsp(pop && (head_src == SRC_INST), mem_rsp);
        data_rsp    = route_rsp(pop && (head_src == SRC_DATA), mem_rsp);
    end

    // Starvation counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign outstanding = occ;
    assign rsp_error   = rsp_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the memory by
// driving mem_rsp by hand with the latency each scenario needs.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    memory_io_req inst_req, data_req, mem_req;
    memory_io_rsp inst_rsp, data_rsp, mem_rsp;
    logic         inst_ready, data_ready, rsp_error;
    logic [1:0]   outstanding;

    int checks = 0;
    int passes = 0;

    mem_port_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_ready  (inst_ready),
        .inst_rsp    (inst_rsp),
        .data_req    (data_req),
        .data_ready  (data_ready),
        .data_rsp    (data_rsp),
        .mem_req     (mem_req),
        .mem_rsp     (mem_rsp),
        .outstanding (outstanding),
        .rsp_error   (rsp_error)
    );

    always #5 clk = ~clk;

    function automatic memory_io_req mk_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
        memory_io_req r;
        r.valid = 1'b1;
        r.write = wr;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    function automatic memory_io_rsp mk_rsp(input logic [31:0] d);
        memory_io_rsp r;
        r.valid = 1'b1;
        r.rdata = d;
        return r;
    endfunction

    task automatic idle_inputs();
        inst_req = '0;
        data_req = '0;
        mem_rsp  = '0;
    endtask

    // Outputs must be zero under reset even with every input active.
    task automatic test_reset();
        reset    = 1'b1;
        inst_req = mk_req(1'b0, 32'h100, 32'h0);
        data_req = mk_req(1'b1, 32'h200, 32'h55);
        mem_rsp  = mk_rsp(32'hdead);
        @(negedge clk); #1;
        checks++; if (inst_ready !== 1'b0) $display("[TB] FAIL reset_inst_ready: got %b want 0", inst_ready); else passes++;
        checks++; if (data_ready !== 1'b0) $display("[TB] FAIL reset_data_ready: got %b want 0", data_ready); else passes++;
        checks++; if (mem_req !== ARB_RESET) $display("[TB] FAIL reset_mem_req: got %h want 0", mem_req); else passes++;
        checks++; if (inst_rsp !== ARB_RSP_RESET) $display("[TB] FAIL reset_inst_rsp: got %h want 0", inst_rsp); else passes++;
        checks++; if (data_rsp !== ARB_RSP_RESET) $display("[TB] FAIL reset_data_rsp: got %h want 0", data_rsp); else passes++;
        checks++; if (outstanding !== 2'd0) $display("[TB] FAIL reset_outstanding: got %0d want 0", outstanding); else passes++;
        checks++; if (rsp_error !== 1'b0) $display("[TB] FAIL reset_rsp_error: got %b want 0", rsp_error); else passes++;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Three back-to-back fetches with memory latency 1.
    task automatic test_fetch_only();
        memory_io_req exp_req;
        memory_io_rsp exp_rsp;
        logic [1:0]   exp_occ;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            inst_req = (k < 3) ? mk_req(1'b0, 32'h100 + 32'(4 * k), 32'h0) : '0;
            mem_rsp  = (k >= 1 && k <= 3) ? mk_rsp(32'hA000_0100 + 32'(4 * (k - 1))) : '0;
            exp_req  = (k < 3) ? mk_req(1'b0, 32'h100 + 32'(4 * k), 32'h0) : ARB_RESET;
            exp_rsp  = (k >= 1 && k <= 3) ? mk_rsp(32'hA000_0100 + 32'(4 * (k - 1))) : ARB_RSP_RESET;
            exp_occ  = (k >= 1 && k <= 3) ? 2'd1 : 2'd0;
            #1;
            checks++; if (inst_ready !== (k < 3)) $display("[TB] FAIL fetch_inst_ready[%0d]: got %b want %b", k, inst_ready, (k < 3)); else passes++;
            checks++; if (data_ready !== 1'b0) $display("[TB] FAIL fetch_data_ready[%0d]: got %b want 0", k, data_ready); else passes++;
            checks++; if (mem_req !== exp_req) $display("[TB] FAIL fetch_mem_req[%0d]: got %h want %h", k, mem_req, exp_req); else passes++;
            checks++; if (inst_rsp !== exp_rsp) $display("[TB] FAIL fetch_inst_rsp[%0d]: got %h want %h", k, inst_rsp, exp_rsp); else passes++;
            checks++; if (data_rsp.valid !== 1'b0) $display("[TB] FAIL fetch_data_rsp_valid[%0d]: got %b want 0", k, data_rsp.valid); else passes++;
            checks++; if (outstanding !== exp_occ) $display("[TB] FAIL fetch_outstanding[%0d]: got %0d want %0d", k, outstanding, exp_occ); else passes++;
        end
        idle_inputs();
    endtask

    // Both channels always requesting, latency 1: fetch wins every fifth grant.
    task automatic test_starvation();
        string        seq = "DDDDIDDDDI";
        logic         exp_i, exp_d, prev_i, prev_d;
        logic [1:0]   exp_occ;
        memory_io_req exp_req;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 10) begin
                inst_req = mk_req(1'b0, 32'h20 + 32'(4 * k), 32'h0);
                data_req = mk_req(1'b0, 32'h300 + 32'(4 * k), 32'h0);
            end else begin
                inst_req = '0;
                data_req = '0;
            end
            mem_rsp = (k >= 1 && k <= 10) ? mk_rsp(32'hB000 + 32'(k)) : '0;
            exp_i   = (k < 10) && (seq[k] == "I");
            exp_d   = (k < 10) && (seq[k] == "D");
            prev_i  = (k >= 1 && k <= 10) && (seq[k - 1] == "I");
            prev_d  = (k >= 1 && k <= 10) && (seq[k - 1] == "D");
            exp_occ = (k >= 1 && k <= 10) ? 2'd1 : 2'd0;
            exp_req = exp_i ? mk_req(1'b0, 32'h20 + 32'(4 * k), 32'h0)
                    : exp_d ? mk_req(1'b0, 32'h300 + 32'(4 * k), 32'h0) : ARB_RESET;
            #1;
            checks++; if (inst_ready !== exp_i) $display("[TB] FAIL starve_inst_ready[%0d]: got %b want %b", k, inst_ready, exp_i); else passes++;
            checks++; if (data_ready !== exp_d) $display("[TB] FAIL starve_data_ready[%0d]: got %b want %b", k, data_ready, exp_d); else passes++;
            checks++; if (mem_req !== exp_req) $display("[TB] FAIL starve_mem_req[%0d]: got %h want %h", k, mem_req, exp_req); else passes++;
            checks++; if (inst_rsp.valid !== prev_i) $display("[TB] FAIL starve_inst_rsp_valid[%0d]: got %b want %b", k, inst_rsp.valid, prev_i); else passes++;
            checks++; if (data_rsp.valid !== prev_d) $display("[TB] FAIL starve_data_rsp_valid[%0d]: got %b want %b", k, data_rsp.valid, prev_d); else passes++;
            checks++; if (outstanding !== exp_occ) $display("[TB] FAIL starve_outstanding[%0d]: got %0d want %0d", k, outstanding, exp_occ); else passes++;
        end
        idle_inputs();
    endtask

    // Latency-5 memory fills the two-entry FIFO and blocks further grants.
    task automatic test_full_fifo();
        int           occ_tab [13] = '{0, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 0};
        logic         exp_d;
        memory_io_rsp exp_rsp;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 0)               data_req = mk_req(1'b0, 32'h400, 32'h0);
            else if (k == 1)          data_req = mk_req(1'b0, 32'h404, 32'h0);
            else if (k >= 2 && k <= 6) data_req = mk_req(1'b0, 32'h408, 32'h0);
            else                      data_req = '0;
            if (k == 5)       mem_rsp = mk_rsp(32'hC0);
            else if (k == 6)  mem_rsp = mk_rsp(32'hC1);
            else if (k == 11) mem_rsp = mk_rsp(32'hC2);
            else              mem_rsp = '0;
            exp_d   = (k == 0) || (k == 1) || (k == 6);
            exp_rsp = (k == 5) ? mk_rsp(32'hC0) : (k == 6) ? mk_rsp(32'hC1) : (k == 11) ? mk_rsp(32'hC2) : ARB_RSP_RESET;
            #1;
            checks++; if (data_ready !== exp_d) $display("[TB] FAIL full_data_ready[%0d]: got %b want %b", k, data_ready, exp_d); else passes++;
            checks++; if (inst_ready !== 1'b0) $display("[TB] FAIL full_inst_ready[%0d]: got %b want 0", k, inst_ready); else passes++;
            checks++; if (mem_req.valid !== exp_d) $display("[TB] FAIL full_mem_valid[%0d]: got %b want %b", k, mem_req.valid, exp_d); else passes++;
            checks++; if (data_rsp !== exp_rsp) $display("[TB] FAIL full_data_rsp[%0d]: got %h want %h", k, data_rsp, exp_rsp); else passes++;
            checks++; if (outstanding !== 2'(occ_tab[k])) $display("[TB] FAIL full_outstanding[%0d]: got %0d want %0d", k, outstanding, occ_tab[k]); else passes++;
        end
        idle_inputs();
    endtask

    // Grants D(load), I, D(store); responses must follow the grant order.
    task automatic test_mixed_routing();
        memory_io_req store_req;
        store_req = mk_req(1'b1, 32'h204, 32'h1234_5678);
        @(negedge clk);
        data_req = mk_req(1'b0, 32'h200, 32'h0);
        #1;
        checks++; if (data_ready !== 1'b1) $display("[TB] FAIL mix_c0_data_ready: got %b want 1", data_ready); else passes++;
        checks++; if (mem_req !== mk_req(1'b0, 32'h200, 32'h0)) $display("[TB] FAIL mix_c0_mem_req: got %h want load 0x200", mem_req); else passes++;
        @(negedge clk);
        data_req = '0;
        inst_req = mk_req(1'b0, 32'h10, 32'h0);
        mem_rsp  = mk_rsp(32'hD0);
        #1;
        checks++; if (inst_ready !== 1'b1) $display("[TB] FAIL mix_c1_inst_ready: got %b want 1", inst_ready); else passes++;
        checks++; if (data_rsp !== mk_rsp(32'hD0)) $display("[TB] FAIL mix_c1_data_rsp: got %h want %h", data_rsp, mk_rsp(32'hD0)); else passes++;
        checks++; if (inst_rsp.valid !== 1'b0) $display("[TB] FAIL mix_c1_inst_rsp_valid: got %b want 0", inst_rsp.valid); else passes++;
        @(negedge clk);
        inst_req = '0;
        data_req = store_req;
        mem_rsp  = mk_rsp(32'hD1);
        #1;
        checks++; if (mem_req !== store_req) $display("[TB] FAIL mix_c2_mem_req: got %h want %h", mem_req, store_req); else passes++;
        checks++; if (inst_rsp !== mk_rsp(32'hD1)) $display("[TB] FAIL mix_c2_inst_rsp: got %h want %h", inst_rsp, mk_rsp(32'hD1)); else passes++;
        checks++; if (data_rsp.valid !== 1'b0) $display("[TB] FAIL mix_c2_data_rsp_valid: got %b want 0", data_rsp.valid); else passes++;
        checks++; if (outstanding !== 2'd1) $display("[TB] FAIL mix_c2_outstanding: got %0d want 1", outstanding); else passes++;
        @(negedge clk);
        data_req = '0;
        mem_rsp  = mk_rsp(32'hD2);
        #1;
        checks++; if (data_rsp !== mk_rsp(32'hD2)) $display("[TB] FAIL mix_c3_data_rsp: got %h want %h", data_rsp, mk_rsp(32'hD2)); else passes++;
        checks++; if (inst_rsp.valid !== 1'b0) $display("[TB] FAIL mix_c3_inst_rsp_valid: got %b want 0", inst_rsp.valid); else passes++;
        @(negedge clk);
        mem_rsp = '0;
        #1;
        checks++; if (outstanding !== 2'd0) $display("[TB] FAIL mix_c4_outstanding: got %0d want 0", outstanding); else passes++;
    endtask

    // A response with nothing outstanding is dropped and flags the error.
    task automatic test_stray_response();
        @(negedge clk);
        mem_rsp = mk_rsp(32'hEE);
        #1;
        checks++; if (inst_rsp.valid !== 1'b0) $display("[TB] FAIL stray_inst_rsp_valid: got %b want 0", inst_rsp.valid); else passes++;
        checks++; if (data_rsp.valid !== 1'b0) $display("[TB] FAIL stray_data_rsp_valid: got %b want 0", data_rsp.valid); else passes++;
        checks++; if (rsp_error !== 1'b0) $display("[TB] FAIL stray_error_same_cycle: got %b want 0", rsp_error); else passes++;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            mem_rsp = '0;
            #1;
            checks++; if (rsp_error !== 1'b1) $display("[TB] FAIL stray_error_sticky[%0d]: got %b want 1", k, rsp_error); else passes++;
        end
    endtask

    // Asynchronous reset with two requests in flight, then a late response.
    task automatic test_reset_mid();
        @(negedge clk);
        data_req = mk_req(1'b0, 32'h500, 32'h0);
        #1;
        checks++; if (data_ready !== 1'b1) $display("[TB] FAIL rmid_c0_data_ready: got %b want 1", data_ready); else passes++;
        @(negedge clk);
        data_req = '0;
        inst_req = mk_req(1'b0, 32'h504, 32'h0);
        #1;
        checks++; if (inst_ready !== 1'b1) $display("[TB] FAIL rmid_c1_inst_ready: got %b want 1", inst_ready); else passes++;
        @(negedge clk);
        inst_req = '0;
        #1;
        checks++; if (outstanding !== 2'd2) $display("[TB] FAIL rmid_pre_outstanding: got %0d want 2", outstanding); else passes++;
        checks++; if (rsp_error !== 1'b1) $display("[TB] FAIL rmid_pre_rsp_error: got %b want 1", rsp_error); else passes++;
        #2;
        reset    = 1'b1;
        data_req = mk_req(1'b0, 32'h508, 32'h0);
        #1;
        checks++; if (outstanding !== 2'd0) $display("[TB] FAIL rmid_async_outstanding: got %0d want 0", outstanding); else passes++;
        checks++; if (rsp_error !== 1'b0) $display("[TB] FAIL rmid_async_rsp_error: got %b want 0", rsp_error); else passes++;
        checks++; if (data_ready !== 1'b0) $display("[TB] FAIL rmid_in_reset_data_ready: got %b want 0", data_ready); else passes++;
        checks++; if (mem_req !== ARB_RESET) $display("[TB] FAIL rmid_in_reset_mem_req: got %h want 0", mem_req); else passes++;
        @(negedge clk);
        reset    = 1'b0;
        data_req = '0;
        mem_rsp  = mk_rsp(32'hF0);
        #1;
        checks++; if (inst_rsp.valid !== 1'b0) $display("[TB] FAIL rmid_late_inst_rsp_valid: got %b want 0", inst_rsp.valid); else passes++;
        checks++; if (data_rsp.valid !== 1'b0) $display("[TB] FAIL rmid_late_data_rsp_valid: got %b want 0", data_rsp.valid); else passes++;
        checks++; if (rsp_error !== 1'b0) $display("[TB] FAIL rmid_late_error_same_cycle: got %b want 0", rsp_error); else passes++;
        @(negedge clk);
        mem_rsp  = '0;
        inst_req = mk_req(1'b0, 32'h600, 32'h0);
        #1;
        checks++; if (rsp_error !== 1'b1) $display("[TB] FAIL rmid_late_error_set: got %b want 1", rsp_error); else passes++;
        checks++; if (inst_ready !== 1'b1) $display("[TB] FAIL rmid_next_inst_ready: got %b want 1", inst_ready); else passes++;
        checks++; if (mem_req !== mk_req(1'b0, 32'h600, 32'h0)) $display("[TB] FAIL rmid_next_mem_req: got %h want fetch 0x600", mem_req); else passes++;
        checks++; if (outstanding !== 2'd0) $display("[TB] FAIL rmid_next_outstanding_before: got %0d want 0", outstanding); else passes++;
        @(negedge clk);
        inst_req = '0;
        #1;
        checks++; if (outstanding !== 2'd1) $display("[TB] FAIL rmid_next_outstanding_after: got %0d want 1", outstanding); else passes++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_starvation();
        test_full_fifo();
        test_mixed_routing();
        test_stray_response();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
